// File: rtl/axi_wr_arbiter_2m_if.sv
// Write-channel handshake bundle between two AXI masters, the arbiter and the single slave port.
// Payload buses are not carried here; they go through the external muxes steered by sel.
interface axi_wr_arbiter_2m_if;
    logic M0_AWVALID;
    logic M0_AWREADY;
    logic M1_AWVALID;
    logic M1_AWREADY;
    logic M0_WVALID;
    logic M0_WLAST;
    logic M0_WREADY;
    logic M1_WVALID;
    logic M1_WLAST;
    logic M1_WREADY;
    logic S_AWVALID;
    logic S_AWREADY;
    logic S_WVALID;
    logic S_WLAST;
    logic S_WREADY;

    // Arbiter side of the bundle
    modport slave (
        input  M0_AWVALID, M1_AWVALID,
        input  M0_WVALID, M0_WLAST, M1_WVALID, M1_WLAST,
        input  S_AWREADY, S_WREADY,
        output M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY,
        output S_AWVALID, S_WVALID, S_WLAST
    );

    // Environment side: both masters plus the downstream slave
    modport master (
        output M0_AWVALID, M1_AWVALID,
        output M0_WVALID, M0_WLAST, M1_WVALID, M1_WLAST,
        output S_AWREADY, S_WREADY,
        input  M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY,
        input  S_AWVALID, S_WVALID, S_WLAST
    );
endinterface

// File: rtl/axi_wr_arbiter_2m.sv
// Two-master round-robin AXI write arbiter: holds one grant from AW handshake through WLAST
// and drives the registered mux select for the write datapath.
module axi_wr_arbiter_2m #(
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 9
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axi_wr_arbiter_2m_if.slave   bus,
    output logic                 sel,
    output logic                 busy,
    output logic [CNT_W-1:0]     beat_count,
    output logic                 err_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    state_t           state_q;
    logic             sel_q;
    logic             last_served_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic grant_d;
    logic req_any_s;
    logic s_awvalid_s, s_wvalid_s, s_wlast_s;
    logic m0_awready_s, m1_awready_s, m0_wready_s, m1_wready_s;
    logic aw_hs_s, w_hs_s;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant_d   = 1'b0;
        req_any_s = bus.M0_AWVALID | bus.M1_AWVALID;
        if (bus.M0_AWVALID && !bus.M1_AWVALID) begin
            grant_d = 1'b0;
        end else if (!bus.M0_AWVALID && bus.M1_AWVALID) begin
            grant_d = 1'b1;
        end else begin
            grant_d = ~last_served_q;
        end
    end

    // Handshake gating from registered state; no READY feeds back into a VALID
    always_comb begin
        s_awvalid_s  = 1'b0;
        s_wvalid_s   = 1'b0;
        s_wlast_s    = 1'b0;
        m0_awready_s = 1'b0;
        m1_awready_s = 1'b0;
        m0_wready_s  = 1'b0;
        m1_wready_s  = 1'b0;
        case (state_q)
            ADDR: begin
                s_awvalid_s  = sel_q ? bus.M1_AWVALID : bus.M0_AWVALID;
                m0_awready_s = ~sel_q & bus.S_AWREADY;
                m1_awready_s =  sel_q & bus.S_AWREADY;
            end
            DATA: begin
                s_wvalid_s  = sel_q ? bus.M1_WVALID : bus.M0_WVALID;
                s_wlast_s   = sel_q ? bus.M1_WLAST  : bus.M0_WLAST;
                m0_wready_s = ~sel_q & bus.S_WREADY;
                m1_wready_s =  sel_q & bus.S_WREADY;
            end
            default: begin
                s_awvalid_s = 1'b0;
            end
        endcase
        aw_hs_s = s_awvalid_s & bus.S_AWREADY;
        w_hs_s  = s_wvalid_s & bus.S_WREADY;
    end

    assign bus.S_AWVALID  = s_awvalid_s;
    assign bus.S_WVALID   = s_wvalid_s;
    assign bus.S_WLAST    = s_wlast_s;
    assign bus.M0_AWREADY = m0_awready_s;
    assign bus.M1_AWREADY = m1_awready_s;
    assign bus.M0_WREADY  = m0_wready_s;
    assign bus.M1_WREADY  = m1_wready_s;

    // Arbitration FSM with grant, beat counter and sticky overrun flag
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= IDLE;
            sel_q         <= 1'b0;
            last_served_q <= 1'b1;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any_s) begin
                        sel_q   <= grant_d;
                        busy_q  <= 1'b1;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs_s) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs_s) begin
                        if (cnt_q != MAX_CNT) begin
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        // The MAX_BEATS-th beat without WLAST is the overrun point
                        if (!s_wlast_s && (cnt_q >= LAST_CNT)) begin
                            err_q <= 1'b1;
                        end
                        if (s_wlast_s) begin
                            last_served_q <= sel_q;
                            busy_q        <= 1'b0;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign busy        = busy_q;
    assign beat_count  = cnt_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter_2m.sv
// Directed bench for axi_wr_arbiter_2m: a per-cycle vector table plus hand-written
// sequences for the overrun burst and the mid-burst asynchronous reset.
module tb_axi_wr_arbiter_2m;
    localparam int CNT_W     = 9;
    localparam int MAX_BEATS = 256;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic             sel;
    logic             busy;
    logic             err_overrun;
    logic [CNT_W-1:0] beat_count;

    axi_wr_arbiter_2m_if bus();

    axi_wr_arbiter_2m #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .bus         (bus),
        .sel         (sel),
        .busy        (busy),
        .beat_count  (beat_count),
        .err_overrun (err_overrun)
    );

    always #5 ACLK = ~ACLK;

    // in    : {m0_awv, m1_awv, m0_wv, m0_wl, m1_wv, m1_wl, s_awr, s_wr}
    // flags : {m0_awr, m1_awr, m0_wr, m1_wr, s_awv, s_wv, s_wl, sel, busy, err}
    typedef struct {
        logic [7:0] in;
        logic [9:0] flags;
        int         bc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [7:0] in, input logic [9:0] flags, input int bc);
        vec_t v;
        v.in    = in;
        v.flags = flags;
        v.bc    = bc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] in);
        {bus.M0_AWVALID, bus.M1_AWVALID, bus.M0_WVALID, bus.M0_WLAST,
         bus.M1_WVALID, bus.M1_WLAST, bus.S_AWREADY, bus.S_WREADY} = in;
    endtask

    task automatic check(input string name, input logic [9:0] flags, input int bc);
        logic [18:0] got;
        logic [18:0] exp;
        got = {bus.M0_AWREADY, bus.M1_AWREADY, bus.M0_WREADY, bus.M1_WREADY,
               bus.S_AWVALID, bus.S_WVALID, bus.S_WLAST, sel, busy, err_overrun, beat_count};
        exp = {flags, 9'(bc)};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got flags=%b bc=%0d, expected flags=%b bc=%0d",
                     name, got[18:9], got[8:0], exp[18:9], exp[8:0]);
        end
    endtask

    // Inputs change at the falling edge, outputs sampled 1 ns later, DUT clocks on the rising edge
    task automatic step(input logic [7:0] in, input logic [9:0] flags, input int bc, input string name);
        drive(in);
        #1;
        check(name, flags, bc);
        @(negedge ACLK);
    endtask

    initial begin
        // Single M0 burst, 4 beats; M1 also drives WVALID but must never see WREADY
        add(8'b1000_0000, 10'b0000_0000_00, 0);
        add(8'b1000_0010, 10'b1000_1000_10, 0);
        add(8'b0010_1001, 10'b0010_0100_10, 0);
        add(8'b0010_1001, 10'b0010_0100_10, 1);
        add(8'b0010_1001, 10'b0010_0100_10, 2);
        add(8'b0011_1001, 10'b0010_0110_10, 3);
        add(8'b0000_0000, 10'b0000_0000_00, 4);
        // Contention every burst, 1 beat each: M0 was served last so M1, M0, M1, M0
        add(8'b1100_0000, 10'b0000_0000_00, 4);
        add(8'b1100_0010, 10'b0100_1001_10, 4);
        add(8'b0011_1101, 10'b0001_0111_10, 0);
        add(8'b1100_0000, 10'b0000_0001_00, 1);
        add(8'b1100_0010, 10'b1000_1000_10, 1);
        add(8'b0011_1101, 10'b0010_0110_10, 0);
        add(8'b1100_0000, 10'b0000_0000_00, 1);
        add(8'b1100_0010, 10'b0100_1001_10, 1);
        add(8'b0011_1101, 10'b0001_0111_10, 0);
        add(8'b1100_0000, 10'b0000_0001_00, 1);
        add(8'b1100_0010, 10'b1000_1000_10, 1);
        add(8'b0011_1101, 10'b0010_0110_10, 0);
        // M1 burst with S_WREADY toggling; M0 drives opposite WLAST to expose routing
        add(8'b0100_0000, 10'b0000_0000_00, 1);
        add(8'b0100_0010, 10'b0100_1001_10, 1);
        add(8'b0011_1001, 10'b0001_0101_10, 0);
        add(8'b0011_1000, 10'b0000_0101_10, 1);
        add(8'b0011_1001, 10'b0001_0101_10, 1);
        add(8'b0011_1000, 10'b0000_0101_10, 2);
        add(8'b0010_1101, 10'b0001_0111_10, 2);
        add(8'b0000_0000, 10'b0000_0001_00, 3);
        // M0 WVALID three cycles ahead of AWVALID: no WREADY until DATA
        add(8'b0010_0011, 10'b0000_0001_00, 3);
        add(8'b0010_0011, 10'b0000_0001_00, 3);
        add(8'b0010_0011, 10'b0000_0001_00, 3);
        add(8'b1010_0011, 10'b0000_0001_00, 3);
        add(8'b1010_0001, 10'b0000_1000_10, 3);
        add(8'b1010_0011, 10'b1000_1000_10, 3);
        add(8'b0011_0001, 10'b0010_0110_10, 0);
        add(8'b0000_0000, 10'b0000_0000_00, 1);

        drive(8'b0000_0000);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        check("reset state", 10'b0000_0000_00, 0);
        @(negedge ACLK);
        ARESET = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in, vecs[i].flags, vecs[i].bc, $sformatf("vec%0d", i));
        end

        // Overrun: 257 beats without WLAST, then a WLAST beat closes the burst
        step(8'b1000_0000, 10'b0000_0000_00, 1, "ovr idle");
        step(8'b1000_0010, 10'b1000_1000_10, 1, "ovr addr");
        for (int i = 0; i <= 257; i++) begin
            logic wl;
            logic er;
            wl = (i == 257);
            er = (i >= MAX_BEATS);
            step({3'b001, wl, 4'b0001},
                 {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, wl, 1'b0, 1'b1, er},
                 (i > MAX_BEATS) ? MAX_BEATS : i,
                 $sformatf("ovr beat%0d", i));
        end
        step(8'b0000_0000, 10'b0000_0000_01, 256, "ovr done");

        // Async reset on beat 2 of an M1 burst; afterwards the tie must go to M0 again
        step(8'b1100_0000, 10'b0000_0000_01, 256, "rst idle");
        step(8'b1100_0010, 10'b0100_1001_11, 256, "rst addr m1");
        step(8'b0000_1001, 10'b0001_0101_11, 0, "rst beat1");
        drive(8'b0000_1001);
        #1;
        ARESET = 1'b1;
        #1;
        check("rst async", 10'b0000_0000_00, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        step(8'b1100_0000, 10'b0000_0000_00, 0, "rst idle2");
        step(8'b1100_0010, 10'b1000_1000_10, 0, "rst tie m0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter_2m.md
Name: axi_wr_arbiter_2m

Overview:
- Two-master write-channel arbiter for the AXI interconnect datapath.
- Sits directly upstream of the 2:1 datapath muxes and generates their select.
- Picks one master by round-robin and holds the grant across the AW handshake and the full W burst up to WLAST.
- Gates VALID/READY so only the granted master talks to the single slave port; payload buses are routed by the muxes using sel.

Parameters:
MAX_BEATS, 256, W beats per burst before err_overrun is flagged (AXI4 max burst length)
CNT_W, 9, width of beat_count; must satisfy 2^CNT_W > MAX_BEATS

Ports:
ACLK  input  1  clock, all state on rising edge
ARESET  input  1  asynchronous, active-high reset
M0_AWVALID  input  1  master 0 address valid
M0_AWREADY  output  1  master 0 address ready
M1_AWVALID  input  1  master 1 address valid
M1_AWREADY  output  1  master 1 address ready
M0_WVALID  input  1  master 0 write data valid
M0_WLAST  input  1  master 0 last beat
M0_WREADY  output  1  master 0 write data ready
M1_WVALID  input  1  master 1 write data valid
M1_WLAST  input  1  master 1 last beat
M1_WREADY  output  1  master 1 write data ready
S_AWVALID  output  1  slave address valid
S_AWREADY  input  1  slave address ready
S_WVALID  output  1  slave write data valid
S_WLAST  output  1  slave last beat
S_WREADY  input  1  slave write data ready
sel  output  1  mux select: 0 = master 0 (in1), 1 = master 1 (in2)
busy  output  1  high in ADDR or DATA
beat_count  output  CNT_W  W beats accepted in the current burst
err_overrun  output  1  sticky; burst reached MAX_BEATS without WLAST

Behaviour:
- Reset: state=IDLE, sel=0, last_served=1 (master 0 wins the first tie), beat_count=0, err_overrun=0. All VALID/READY outputs are 0. Reset asserted mid-burst aborts to IDLE immediately.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - All READY/VALID outputs are 0; sel holds the last grant.
  - If exactly one AWVALID is high, grant that master.
  - If both are high, grant the master != last_served.
  - On the next edge: sel <= grant, state <= ADDR. Arbitration latency is 1 cycle.
- ADDR:
  - S_AWVALID = granted AWVALID; granted AWREADY = S_AWREADY; the other master's AWREADY = 0.
  - On handshake (S_AWVALID & S_AWREADY): state <= DATA, beat_count <= 0.
  - A granted master dropping AWVALID before the handshake is a protocol violation. The grant is held; no deassertion recovery is provided.
- DATA:
  - S_WVALID = granted WVALID; S_WLAST = granted WLAST; granted WREADY = S_WREADY; all AW outputs are 0.
  - Each W handshake increments beat_count, saturating at MAX_BEATS.
  - If beat_count reaches MAX_BEATS without a WLAST handshake: err_overrun <= 1, which stays set until reset. The burst still continues.
  - On a W handshake with WLAST=1: state <= IDLE, last_served <= sel, beat_count holds its final value.
- Re-arbitration from IDLE takes 1 cycle, so back-to-back bursts have one idle cycle between them.
- W before AW: W data arriving while in IDLE/ADDR is stalled (WREADY=0) until the corresponding AW completes.
- The ungranted master's AWREADY and WREADY are always 0.
- sel is registered, so it is glitch-free; it changes only on the IDLE->ADDR transition.
- All gating logic is combinational from registered state plus inputs. There is no combinational path from S_*READY to S_*VALID.

Test Plan:
- Reset then M0_AWVALID=1 only -> sel=0, S_AWVALID=1 one cycle later. S_AWREADY=1 -> enters DATA; 4 beats with WLAST on beat 4 -> beat_count=4, back to IDLE, M1_WREADY=0 throughout.
- Both AWVALID high every burst, each burst 1 beat -> grants alternate M0,M1,M0,M1 (sel 0,1,0,1). The first grant after reset goes to M0.
- M1 granted in DATA, S_WREADY toggling 1/0 across 3 beats -> beat_count increments only on handshake cycles to 3. S_WLAST follows M1_WLAST; M0_WREADY=0.
- M0_WVALID=1 asserted 3 cycles before M0_AWVALID -> M0_WREADY=0 until after the AW handshake; the first W handshake occurs in DATA only.
- Burst of 257 beats without WLAST -> err_overrun=1 at beat 256, beat_count saturates at 256. A later WLAST returns to IDLE with err_overrun still 1.
- ARESET pulsed mid-DATA on beat 2 -> all outputs 0 asynchronously, state IDLE. Next contention (both AWVALID) grants M0.
